exe_mem_pipe_reg: RTL

- Parametrised EXE→MEM pipeline register carrying the same fields as the current EXE/MEM stage register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the MEM stage can stall the pipe without a combinational ready path back into EXE.
- Adds a synchronous flush, used for branch mispredict and exception squash.
- Sits between the ALU/EXE stage and data memory.

---
 rtl/exe_mem_pipe_reg_pkg.sv | 16 +
 rtl/pipe_skid_buf.sv | 56 +++++
 rtl/exe_mem_pipe_reg.sv | 74 +++++++
 3 files changed

// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared constants for the EXE->MEM pipeline register: default widths and payload packing.
// Payload layout, MSB to LSB: {mem_read, mem_write, wb_en, dst, alu_res, val_rm}.
package exe_mem_pipe_reg_pkg;

    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_REG_FILE_DEPTH = 16;
    localparam int DEF_REG_ADDR_W     = $clog2(DEF_REG_FILE_DEPTH);
    localparam int DEF_CNT_W          = 16;

    localparam int CTRL_W = 3;

    function automatic int payload_w(input int word_w, input int reg_addr_w);
        return CTRL_W + reg_addr_w + 2 * word_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; main entry drives the outputs.
// Latency 1 cycle; in_ready depends only on skid occupancy, so there is no combinational path from out_ready.
module pipe_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              main_vld;
    logic              skid_vld;
    logic [DATA_W-1:0] main_dat;
    logic [DATA_W-1:0] skid_dat;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_dat;
    assign in_xfer   = in_valid && !skid_vld;
    assign out_xfer  = main_vld && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else if (flush) begin
            // Payload registers keep their values so the data outputs hold the last main entry.
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_xfer) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                main_dat <= in_data;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_dat <= in_data;
            skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready skid buffering, flush and control-bit gating.
// Optional stall counter enabled by EXE_MEM_PIPE_REG_PERF_EN.
module exe_mem_pipe_reg
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef EXE_MEM_PIPE_REG_PERF_EN
   ,parameter int CNT_W      = DEF_CNT_W
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  wb_en_in,
    input  logic [REG_ADDR_W-1:0] dst_in,
    input  logic [WORD_WIDTH-1:0] alu_res_in,
    input  logic [WORD_WIDTH-1:0] val_rm_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  wb_en_out,
    output logic [REG_ADDR_W-1:0] dst_out,
    output logic [WORD_WIDTH-1:0] alu_res_out,
    output logic [WORD_WIDTH-1:0] val_rm_out
`ifdef EXE_MEM_PIPE_REG_PERF_EN
   ,output logic [CNT_W-1:0]      stall_cnt
`endif
);

    localparam int PW = payload_w(WORD_WIDTH, REG_ADDR_W);

    logic [PW-1:0] pay_in;
    logic [PW-1:0] pay_out;
    logic          mem_read_q;
    logic          mem_write_q;
    logic          wb_en_q;

    assign pay_in = {mem_read_in, mem_write_in, wb_en_in, dst_in, alu_res_in, val_rm_in};
    assign {mem_read_q, mem_write_q, wb_en_q, dst_out, alu_res_out, val_rm_out} = pay_out;

    pipe_skid_buf #(.DATA_W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    // A stale or squashed slot must never write memory or the register file.
    assign mem_read_out  = mem_read_q  & out_valid;
    assign mem_write_out = mem_write_q & out_valid;
    assign wb_en_out     = wb_en_q     & out_valid;

`ifdef EXE_MEM_PIPE_REG_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
